// File: rtl/washer_fsm_pkg.sv
// rtl/washer_fsm_pkg.sv - shared state encoding, program codes and phase lengths for the washer controller
package washer_fsm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SOAP_WAIT  = 4'd1,
        ST_FILL_COLD  = 4'd2,
        ST_FILL_HOT   = 4'd3,
        ST_WASH       = 4'd4,
        ST_DRAIN1     = 4'd5,
        ST_RINSE_FILL = 4'd6,
        ST_RINSE      = 4'd7,
        ST_DRAIN2     = 4'd8,
        ST_SPIN       = 4'd9,
        ST_DONE       = 4'd10
    } state_t;

    localparam logic [2:0] PROG_COLD      = 3'b000;
    localparam logic [2:0] PROG_HOT       = 3'b001;
    localparam logic [2:0] PROG_RINSE_DRY = 3'b010;
    localparam logic [2:0] PROG_DRY       = 3'b011;

    localparam int DEF_FILL_T  = 10;
    localparam int DEF_WASH_T  = 20;
    localparam int DEF_DRAIN_T = 10;
    localparam int DEF_RINSE_T = 15;
    localparam int DEF_SPIN_T  = 15;

    function automatic logic is_timed(state_t s);
        return s inside {ST_FILL_COLD, ST_FILL_HOT, ST_WASH, ST_DRAIN1,
                         ST_RINSE_FILL, ST_RINSE, ST_DRAIN2, ST_SPIN};
    endfunction

endpackage

// File: rtl/washer_fsm_phase_timer.sv
// rtl/washer_fsm_phase_timer.sv - 8-bit loadable down-counter timing each washer phase
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] count,
    output logic       last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign last = (count == 8'd1);

endmodule

// File: rtl/washer_fsm.sv
// rtl/washer_fsm.sv - Moore program controller sequencing fill, wash, drain, rinse and spin phases
module washer_fsm
    import washer_fsm_pkg::*;
#(
    parameter int FILL_T  = DEF_FILL_T,
    parameter int WASH_T  = DEF_WASH_T,
    parameter int DRAIN_T = DEF_DRAIN_T,
    parameter int RINSE_T = DEF_RINSE_T,
    parameter int SPIN_T  = DEF_SPIN_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic [2:0] program_selection,
    input  logic       start,
    input  logic       doorclosed,
    input  logic       soap,
    output logic       valve_in_cold,
    output logic       valve_in_hot,
    output logic       valve_out,
    output logic       motor,
    output logic [7:0] timer_display,
    output logic       program_done,
    output logic       soap_warning
);

    localparam logic [7:0] FILL_N  = 8'(FILL_T);
    localparam logic [7:0] WASH_N  = 8'(WASH_T);
    localparam logic [7:0] DRAIN_N = 8'(DRAIN_T);
    localparam logic [7:0] RINSE_N = 8'(RINSE_T);
    localparam logic [7:0] SPIN_N  = 8'(SPIN_T);

    state_t     current_state;
    state_t     next_state;
    logic [2:0] prog_q;
    logic [2:0] prog_d;
    logic       paused_q;
    logic       paused_d;

    logic       t_clear;
    logic       t_load;
    logic [7:0] t_val;
    logic       t_en;
    logic [7:0] t_count;
    logic       t_last;

    function automatic state_t succ(state_t s);
        case (s)
            ST_FILL_COLD,
            ST_FILL_HOT:   return ST_WASH;
            ST_WASH:       return ST_DRAIN1;
            ST_DRAIN1:     return ST_RINSE_FILL;
            ST_RINSE_FILL: return ST_RINSE;
            ST_RINSE:      return ST_DRAIN2;
            ST_DRAIN2:     return ST_SPIN;
            ST_SPIN:       return ST_DONE;
            default:       return ST_IDLE;
        endcase
    endfunction

    // Non-timed states load 0 so the display reads 0 outside timed phases.
    function automatic logic [7:0] dur(state_t s);
        case (s)
            ST_FILL_COLD,
            ST_FILL_HOT,
            ST_RINSE_FILL: return FILL_N;
            ST_WASH:       return WASH_N;
            ST_DRAIN1,
            ST_DRAIN2:     return DRAIN_N;
            ST_RINSE:      return RINSE_N;
            ST_SPIN:       return SPIN_N;
            default:       return 8'd0;
        endcase
    endfunction

    phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (t_clear),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .count    (t_count),
        .last     (t_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_state <= ST_IDLE;
            prog_q        <= PROG_COLD;
            paused_q      <= 1'b0;
        end else begin
            current_state <= next_state;
            prog_q        <= prog_d;
            paused_q      <= paused_d;
        end
    end

    always_comb begin
        next_state = current_state;
        prog_d     = prog_q;
        t_clear    = 1'b0;
        t_load     = 1'b0;
        t_val      = 8'd0;
        t_en       = 1'b0;
        paused_d   = 1'b0;

        if (!power) begin
            next_state = ST_IDLE;
            t_clear    = 1'b1;
        end else begin
            case (current_state)
                ST_IDLE, ST_DONE: begin
                    if (start && doorclosed && !program_selection[2]) begin
                        prog_d = program_selection;
                        case (program_selection)
                            PROG_COLD, PROG_HOT: begin
                                if (soap) begin
                                    next_state = (program_selection == PROG_HOT) ? ST_FILL_HOT
                                                                                  : ST_FILL_COLD;
                                end else begin
                                    next_state = ST_SOAP_WAIT;
                                end
                            end
                            PROG_RINSE_DRY: next_state = ST_RINSE_FILL;
                            default:        next_state = ST_SPIN;
                        endcase
                        t_load = 1'b1;
                        t_val  = dur(next_state);
                    end
                end
                ST_SOAP_WAIT: begin
                    if (soap) begin
                        next_state = (prog_q == PROG_HOT) ? ST_FILL_HOT : ST_FILL_COLD;
                        t_load     = 1'b1;
                        t_val      = FILL_N;
                    end
                end
                default: begin
                    // Door open freezes state and counter; actuators drop on the next cycle.
                    if (!doorclosed) begin
                        paused_d = is_timed(current_state);
                    end else if (t_last) begin
                        next_state = succ(current_state);
                        t_load     = 1'b1;
                        t_val      = dur(next_state);
                    end else begin
                        t_en = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        valve_in_cold = 1'b0;
        valve_in_hot  = 1'b0;
        valve_out     = 1'b0;
        motor         = 1'b0;
        program_done  = 1'b0;
        soap_warning  = 1'b0;
        case (current_state)
            ST_FILL_COLD,
            ST_RINSE_FILL: valve_in_cold = !paused_q;
            ST_FILL_HOT:   valve_in_hot  = !paused_q;
            ST_WASH,
            ST_RINSE:      motor         = !paused_q;
            ST_DRAIN1,
            ST_DRAIN2:     valve_out     = !paused_q;
            ST_SPIN: begin
                valve_out = !paused_q;
                motor     = !paused_q;
            end
            ST_DONE:       program_done  = 1'b1;
            ST_SOAP_WAIT:  soap_warning  = 1'b1;
            default: ;
        endcase
    end

    assign timer_display = t_count;

endmodule

// File: tb/tb_washer_fsm.sv
// tb/tb_washer_fsm.sv - scoreboard bench comparing washer_fsm against a phase-list reference model
module tb_washer_fsm;
    import washer_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic [2:0] program_selection;
    logic       start;
    logic       doorclosed;
    logic       soap;
    logic       valve_in_cold;
    logic       valve_in_hot;
    logic       valve_out;
    logic       motor;
    logic [7:0] timer_display;
    logic       program_done;
    logic       soap_warning;

    always #5 clk = ~clk;

    washer_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .power             (power),
        .program_selection (program_selection),
        .start             (start),
        .doorclosed        (doorclosed),
        .soap              (soap),
        .valve_in_cold     (valve_in_cold),
        .valve_in_hot      (valve_in_hot),
        .valve_out         (valve_out),
        .motor             (motor),
        .timer_display     (timer_display),
        .program_done      (program_done),
        .soap_warning      (soap_warning)
    );

    typedef struct packed {
        logic       is_idle;
        logic       cold;
        logic       hot;
        logic       vout;
        logic       motor;
        logic [7:0] disp;
        logic       done;
        logic       warn;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   finished = 0;

    // Reference model: mode 0 idle, 1 soap wait, 2 running, 3 done.
    // Phase kinds: 0 cold fill, 1 hot fill, 2 wash, 3 drain, 4 rinse, 5 spin.
    int m_mode = 0;
    int m_phases[$];
    int m_rem = 0;
    bit m_paused = 0;

    function automatic int phase_len(int k);
        case (k)
            0, 1:    return 10;
            2:       return 20;
            3:       return 10;
            default: return 15;
        endcase
    endfunction

    task automatic build(input logic [2:0] sel);
        case (sel)
            3'd0:    m_phases = '{0, 2, 3, 0, 4, 3, 5};
            3'd1:    m_phases = '{1, 2, 3, 0, 4, 3, 5};
            3'd2:    m_phases = '{0, 4, 3, 5};
            default: m_phases = '{5};
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.is_idle = (m_mode == 0);
        e.warn    = (m_mode == 1);
        e.done    = (m_mode == 3);
        if (m_mode == 2) begin
            e.disp = 8'(m_rem);
            if (!m_paused) begin
                case (m_phases[0])
                    0:       e.cold = 1'b1;
                    1:       e.hot  = 1'b1;
                    2, 4:    e.motor = 1'b1;
                    3:       e.vout = 1'b1;
                    default: begin e.vout = 1'b1; e.motor = 1'b1; end
                endcase
            end
        end
        return e;
    endfunction

    task automatic model_update(input bit p, input logic [2:0] sel, input bit st,
                                input bit d, input bit so);
        if (!rst || !p) begin
            m_mode = 0;
            m_paused = 0;
            m_rem = 0;
            m_phases.delete();
        end else begin
            case (m_mode)
                0, 3: begin
                    if (st && d && sel < 3'd4) begin
                        build(sel);
                        if (sel < 3'd2 && !so) begin
                            m_mode = 1;
                            m_rem = 0;
                        end else begin
                            m_mode = 2;
                            m_rem = phase_len(m_phases[0]);
                        end
                    end
                end
                1: begin
                    if (so) begin
                        m_mode = 2;
                        m_rem = phase_len(m_phases[0]);
                    end
                end
                default: begin
                    if (!d) begin
                        m_paused = 1;
                    end else begin
                        m_paused = 0;
                        if (m_rem == 1) begin
                            void'(m_phases.pop_front());
                            if (m_phases.size() == 0) begin
                                m_mode = 3;
                                m_rem = 0;
                            end else begin
                                m_rem = phase_len(m_phases[0]);
                            end
                        end else begin
                            m_rem = m_rem - 1;
                        end
                    end
                end
            endcase
        end
    endtask

    // Called just after a rising edge: queue this cycle's expectation, then drive and advance the model.
    task automatic step(input bit p, input logic [2:0] sel, input bit st, input bit d, input bit so);
        exp_q.push_back(model_out());
        power = p;
        program_selection = sel;
        start = st;
        doorclosed = d;
        soap = so;
        model_update(p, sel, st, d, so);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = '0;
            a.is_idle = e.is_idle ? (dut.current_state == ST_IDLE) : 1'b0;
            a.cold  = valve_in_cold;
            a.hot   = valve_in_hot;
            a.vout  = valve_out;
            a.motor = motor;
            a.disp  = timer_display;
            a.done  = program_done;
            a.warn  = soap_warning;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got idle=%b cold=%b hot=%b out=%b motor=%b timer=%0d done=%b warn=%b, want idle=%b cold=%b hot=%b out=%b motor=%b timer=%0d done=%b warn=%b",
                         cyc, a.is_idle, a.cold, a.hot, a.vout, a.motor, a.disp, a.done, a.warn,
                         e.is_idle, e.cold, e.hot, e.vout, e.motor, e.disp, e.done, e.warn);
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        if (!finished) begin
            miscompares++;
            $display("FAIL timeout: stimulus did not complete after 100000 cycles (cycle %0d)", cyc);
            $finish;
        end
    end

    initial begin
        rst = 1'b0;
        power = 1'b1;
        program_selection = 3'b000;
        start = 1'b0;
        doorclosed = 1'b1;
        soap = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 3'b000, 1, 1, 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 3'b000, 0, 1, 1);

        if (dut.current_state !== ST_IDLE || valve_in_cold !== 1'b0 || valve_in_hot !== 1'b0 ||
            valve_out !== 1'b0 || motor !== 1'b0 || timer_display !== 8'd0 ||
            program_done !== 1'b0 || soap_warning !== 1'b0) begin
            miscompares++;
            $display("FAIL reset state: state=%0d cold=%b hot=%b out=%b motor=%b timer=%0d done=%b warn=%b",
                     dut.current_state, valve_in_cold, valve_in_hot, valve_out, motor,
                     timer_display, program_done, soap_warning);
        end

        // Cold wash with soap; selection changes after start must be ignored.
        step(1, 3'b000, 1, 1, 1);
        for (int i = 0; i < 95; i++) step(1, 3'b111, 0, 1, 1);

        // Hot wash without soap, soap arrives after 20 cycles, later soap drops.
        step(1, 3'b001, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 3'b001, 0, 1, 0);
        for (int i = 0; i < 30; i++) step(1, 3'b000, 0, 1, 1);
        for (int i = 0; i < 65; i++) step(1, 3'b000, 0, 1, 0);

        // Rinse+dry, then only dry.
        step(1, 3'b010, 1, 1, 0);
        for (int i = 0; i < 55; i++) step(1, 3'b010, 0, 1, 0);
        step(1, 3'b011, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 3'b011, 0, 1, 0);

        // Cold wash: door open for 5 cycles mid-wash, then power off during rinse.
        step(1, 3'b000, 1, 1, 1);
        for (int i = 1; i < 70; i++) step(1, 3'b000, 0, !(i >= 19 && i <= 23), 1);
        step(0, 3'b000, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 3'b000, 0, 1, 1);

        // Ignored starts: door open, invalid selections.
        step(1, 3'b000, 1, 0, 1);
        step(1, 3'b100, 1, 1, 1);
        step(1, 3'b111, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 3'b000, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit p;
            bit st;
            bit d;
            bit so;
            logic [2:0] sel;
            p   = ($urandom_range(0, 399) != 0);
            sel = 3'($urandom_range(0, 7));
            st  = ($urandom_range(0, 7) == 0);
            d   = ($urandom_range(0, 14) != 0);
            so  = ($urandom_range(0, 2) != 0);
            step(p, sel, st, d, so);
        end

        @(negedge clk);
        #1;
        finished = 1;
        if (miscompares != 0) begin
            $display("FAIL %0d miscompares", miscompares);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
